// File: rtl/controller_interface.sv
// controller_interface: frame-strobed reader for two NES-style serial gamepads.
// Latches both pads, shifts in 8 active-low bits from each, and commits both
// bytes together into CPU-readable registers behind a tristate read port.
module controller_interface #(
    parameter int unsigned HALF_PERIOD = 75
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_fetch,
    input  logic       ctrl_data_1,
    input  logic       ctrl_data_2,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    output logic       busy,
    inout  wire  [7:0] data_out,
    input  logic       SELECT_controller_1,
    input  logic       SELECT_controller_2
);

    localparam int unsigned CW = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_COMMIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic          sample_c;
    logic          commit_c;

    logic d1_meta, d1_sync;
    logic d2_meta, d2_sync;
    logic sf_q, sf_prev;
    logic start_edge_c;

    logic [7:0] shift_1, shift_2;
    logic [7:0] controller_1, controller_2;

    // Two-flop synchronizers for the asynchronous pad data lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d1_meta <= 1'b0;
            d1_sync <= 1'b0;
            d2_meta <= 1'b0;
            d2_sync <= 1'b0;
        end else begin
            d1_meta <= ctrl_data_1;
            d1_sync <= d1_meta;
            d2_meta <= ctrl_data_2;
            d2_sync <= d2_meta;
        end
    end

    // Register the frame strobe and keep one cycle of history for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sf_q    <= 1'b0;
            sf_prev <= 1'b0;
        end else begin
            sf_q    <= start_fetch;
            sf_prev <= sf_q;
        end
    end

    assign start_edge_c = sf_q & ~sf_prev;

    // State, phase counter and bit index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic; the counter reloads on every state change and counts
    // down to zero, which marks the last cycle of the current phase
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sample_c  = 1'b0;
        commit_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge_c) begin
                    state_nxt = S_LATCH;
                    cnt_nxt   = LATCH_LOAD;
                end
            end
            S_LATCH: begin
                cnt_nxt = CW'(cnt - CW'(1));
                if (cnt == '0) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = HALF_LOAD;
                    idx_nxt   = 3'd0;
                end
            end
            S_LOW: begin
                cnt_nxt = CW'(cnt - CW'(1));
                if (cnt == '0) begin
                    sample_c  = 1'b1;
                    state_nxt = S_HIGH;
                    cnt_nxt   = HALF_LOAD;
                end
            end
            S_HIGH: begin
                cnt_nxt = CW'(cnt - CW'(1));
                if (cnt == '0) begin
                    if (idx == 3'd7) begin
                        state_nxt = S_COMMIT;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_LOW;
                        cnt_nxt   = HALF_LOAD;
                        idx_nxt   = 3'(idx + 3'd1);
                    end
                end
            end
            S_COMMIT: begin
                commit_c  = 1'b1;
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pad-facing outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ctrl_latch <= (state_nxt == S_LATCH);
            ctrl_clk   <= (state_nxt == S_HIGH);
            busy       <= (state_nxt != S_IDLE);
        end
    end

    // Capture one inverted (pressed = 1) bit per pad at the end of each low phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_1 <= 8'h00;
            shift_2 <= 8'h00;
        end else if (sample_c) begin
            shift_1[idx] <= ~d1_sync;
            shift_2[idx] <= ~d2_sync;
        end
    end

    // Both CPU-visible bytes update on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            controller_1 <= 8'h00;
            controller_2 <= 8'h00;
        end else if (commit_c) begin
            controller_1 <= shift_1;
            controller_2 <= shift_2;
        end
    end

    // Combinational read port; controller 1 wins when both selects are set
    assign data_out = SELECT_controller_1 ? controller_1 :
                      SELECT_controller_2 ? controller_2 : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_controller_interface.sv
// Scoreboarded bench for controller_interface with two behavioural pad models.
module tb_controller_interface;

    localparam int unsigned H         = 4;
    localparam int unsigned FETCH_WIN = 110;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_fetch;
    logic       ctrl_data_1, ctrl_data_2;
    logic       ctrl_latch, ctrl_clk, busy;
    logic       sel1, sel2;
    wire  [7:0] data_bus;
    logic       tb_drv_en;
    logic [7:0] tb_drv;

    logic [7:0] pad1, pad2;
    logic [7:0] sr1, sr2;
    logic       pclk_d;

    logic [15:0] exp_q[$];
    logic [7:0]  cur1;
    int          n_checks = 0;
    int          n_errors = 0;

    controller_interface #(.HALF_PERIOD(H)) dut (
        .clk                (clk),
        .rst                (rst),
        .start_fetch        (start_fetch),
        .ctrl_data_1        (ctrl_data_1),
        .ctrl_data_2        (ctrl_data_2),
        .ctrl_latch         (ctrl_latch),
        .ctrl_clk           (ctrl_clk),
        .busy               (busy),
        .data_out           (data_bus),
        .SELECT_controller_1(sel1),
        .SELECT_controller_2(sel2)
    );

    assign data_bus = tb_drv_en ? tb_drv : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    // Pad models: parallel load while latched, shift on each ctrl_clk rise
    always @(posedge clk) begin
        if (ctrl_latch) begin
            sr1 <= pad1;
            sr2 <= pad2;
        end else if (ctrl_clk && !pclk_d) begin
            sr1 <= sr1 >> 1;
            sr2 <= sr2 >> 1;
        end
        pclk_d <= ctrl_clk;
    end
    assign ctrl_data_1 = ~sr1[0];
    assign ctrl_data_2 = ~sr2[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic strobe_level(input int n, input bit retrig);
        if (retrig) return (n < 30) || (n >= 35 && n < 45);
        return n < 50;
    endfunction

    // One frame fetch: push expectation, drive strobe, measure waveform, score result
    task automatic run_fetch(input logic [7:0] p1, input logic [7:0] p2,
                             input bit retrig, input bit watch, input string tag);
        int latch_n = 0, pulses = 0, busy_n = 0, rises = 0, glitch = 0;
        bit fall_seen = 0;
        logic clk_prev = 1'b0, busy_prev = 1'b0;
        logic [7:0] old_v = cur1;
        logic [15:0] e;
        pad1 = p1;
        pad2 = p2;
        exp_q.push_back({p1, p2});
        sel1 = watch;
        sel2 = 1'b0;
        for (int n = 0; n < FETCH_WIN; n++) begin
            @(posedge clk); #1;
            start_fetch = strobe_level(n, retrig);
            @(negedge clk);
            latch_n += int'(ctrl_latch);
            busy_n  += int'(busy);
            if (ctrl_clk && !clk_prev) pulses++;
            if (busy && !busy_prev) rises++;
            if (busy_prev && !busy) fall_seen = 1;
            if (watch && (data_bus !== (fall_seen ? p1 : old_v))) glitch++;
            clk_prev  = ctrl_clk;
            busy_prev = busy;
        end
        start_fetch = 1'b0;
        sel1 = 1'b0;
        check({tag, "_latch_cycles"}, latch_n, 2 * H);
        check({tag, "_clk_pulses"}, pulses, 8);
        check({tag, "_busy_cycles"}, busy_n, 18 * H + 1);
        check({tag, "_fetch_count"}, rises, 1);
        if (watch) check({tag, "_atomic_bad_reads"}, glitch, 0);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            @(posedge clk); #1;
            sel1 = 1'b1;
            #1 check({tag, "_read1"}, data_bus, e[15:8]);
            sel1 = 1'b0;
            sel2 = 1'b1;
            #1 check({tag, "_read2"}, data_bus, e[7:0]);
            sel2 = 1'b0;
            cur1 = e[15:8];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic clk_prev;
        bit reached;
        rst = 1'b0;
        start_fetch = 1'b0;
        sel1 = 1'b0;
        sel2 = 1'b0;
        tb_drv_en = 1'b0;
        tb_drv = 8'h00;
        pad1 = 8'h00;
        pad2 = 8'h00;
        cur1 = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_latch", ctrl_latch, 0);
        check("rst_clk", ctrl_clk, 0);
        check("rst_busy", busy, 0);
        sel1 = 1'b1;
        #1 check("rst_read1", data_bus, 8'h00);
        sel1 = 1'b0;
        sel2 = 1'b1;
        #1 check("rst_read2", data_bus, 8'h00);
        sel2 = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);

        run_fetch(8'h5A, 8'hF0, 0, 0, "basic");
        run_fetch(8'hFF, 8'h0F, 0, 0, "preload");
        run_fetch(8'h00, 8'hF0, 0, 1, "atomic");
        run_fetch(8'hA5, 8'h5A, 1, 0, "retrig");
        run_fetch(8'h01, 8'h10, 0, 0, "frame1");
        repeat (2000 - FETCH_WIN - 1) @(posedge clk);
        run_fetch(8'h80, 8'h08, 0, 0, "frame2");
        run_fetch(8'h12, 8'h34, 0, 0, "busval");

        // Tristate: with no select the bench's own driver must win the bus
        @(negedge clk);
        tb_drv_en = 1'b1;
        tb_drv = 8'hA5;
        #1 check("bus_release_a5", data_bus, 8'hA5);
        tb_drv = 8'h5A;
        #1 check("bus_release_5a", data_bus, 8'h5A);
        tb_drv_en = 1'b0;
        sel1 = 1'b1;
        sel2 = 1'b1;
        #1 check("bus_priority", data_bus, 8'h12);
        sel1 = 1'b0;
        sel2 = 1'b0;

        // Mid-fetch reset during the bit-5 high phase
        pad1 = 8'h3C;
        pad2 = 8'hC3;
        pulses = 0;
        clk_prev = 1'b0;
        reached = 0;
        for (int n = 0; n < 200 && !reached; n++) begin
            @(posedge clk); #1;
            start_fetch = (n < 50);
            @(negedge clk);
            if (ctrl_clk && !clk_prev) pulses++;
            clk_prev = ctrl_clk;
            if (pulses == 6) reached = 1;
        end
        check("midrst_reached_bit5", reached, 1);
        rst = 1'b0;
        #1;
        check("midrst_clk", ctrl_clk, 0);
        check("midrst_latch", ctrl_latch, 0);
        check("midrst_busy", busy, 0);
        sel1 = 1'b1;
        #1 check("midrst_read1", data_bus, 8'h00);
        sel1 = 1'b0;
        sel2 = 1'b1;
        #1 check("midrst_read2", data_bus, 8'h00);
        sel2 = 1'b0;
        start_fetch = 1'b0;
        cur1 = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        run_fetch(8'hC3, 8'h3C, 0, 1, "fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
